// File: rtl/memory_reader.sv
// Read-side sequencer: walks the 25 operand addresses, gathers the returned bytes
// in a shadow bank and publishes them to the matrix outputs in a single edge.
module memory_reader (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_i,
  output logic [4:0]   addr_core_o,
  input  logic [7:0]   data_core_i,
  output logic [127:0] a_mat_o,
  output logic [71:0]  b_mat_o,
  output logic         busy_o,
  output logic         load_valid_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t         state_r, state_s;
  logic [4:0]     rd_cnt_r, rd_cnt_s;
  logic [4:0]     addr_r, addr_s;
  logic [4:0]     cap_idx_r;
  logic           cap_vld_r;
  logic           start_q_r;
  logic           start_rise_s;
  logic           busy_r, busy_s;
  logic           load_valid_r, load_valid_s;
  logic [127:0]   a_sh_r, a_sh_s, a_mat_r;
  logic [71:0]    b_sh_r, b_sh_s, b_mat_r;

  assign start_rise_s = start_i & ~start_q_r;

  // Next-state, read-counter and registered-output decode
  always_comb begin
    state_s      = state_r;
    rd_cnt_s     = rd_cnt_r;
    addr_s       = 5'd0;
    case (state_r)
      ST_IDLE: begin
        rd_cnt_s = 5'd0;
        if (start_rise_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (rd_cnt_r == 5'd24) begin
          state_s = ST_DRAIN;
          addr_s  = 5'd24;
        end else begin
          rd_cnt_s = rd_cnt_r + 5'd1;
          addr_s   = rd_cnt_r + 5'd1;
        end
      end
      ST_DRAIN:  state_s = ST_COMMIT;
      ST_COMMIT: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
    busy_s       = (state_s == ST_ISSUE) || (state_s == ST_DRAIN);
    load_valid_s = (state_s == ST_COMMIT);
  end

  // Steer the byte returned for the previous address into its shadow slot
  always_comb begin
    a_sh_s = a_sh_r;
    b_sh_s = b_sh_r;
    for (int i = 0; i < 16; i++) begin
      a_sh_s[i*8 +: 8] = (cap_vld_r && (cap_idx_r == 5'(i))) ? data_core_i : a_sh_r[i*8 +: 8];
    end
    for (int j = 0; j < 9; j++) begin
      b_sh_s[j*8 +: 8] = (cap_vld_r && (cap_idx_r == 5'(j + 16))) ? data_core_i : b_sh_r[j*8 +: 8];
    end
  end

  // Control state, start edge detector and capture pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      rd_cnt_r     <= 5'd0;
      addr_r       <= 5'd0;
      start_q_r    <= 1'b0;
      cap_idx_r    <= 5'd0;
      cap_vld_r    <= 1'b0;
      busy_r       <= 1'b0;
      load_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      rd_cnt_r     <= rd_cnt_s;
      addr_r       <= addr_s;
      start_q_r    <= start_i;
      cap_idx_r    <= rd_cnt_r;
      cap_vld_r    <= (state_r == ST_ISSUE);
      busy_r       <= busy_s;
      load_valid_r <= load_valid_s;
    end
  end

  // Shadow bank and atomic commit; the last byte is merged on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sh_r  <= 128'd0;
      b_sh_r  <= 72'd0;
      a_mat_r <= 128'd0;
      b_mat_r <= 72'd0;
    end else begin
      a_sh_r <= a_sh_s;
      b_sh_r <= b_sh_s;
      if (state_r == ST_DRAIN) begin
        a_mat_r <= a_sh_s;
        b_mat_r <= b_sh_s;
      end
    end
  end

  assign addr_core_o  = addr_r;
  assign a_mat_o      = a_mat_r;
  assign b_mat_o      = b_mat_r;
  assign busy_o       = busy_r;
  assign load_valid_o = load_valid_r;

endmodule

// File: doc/memory_reader.md
# memory_reader

Read-side sequencer for the operand memory. After the capture side loads the 16 A-matrix bytes and 9 B-matrix bytes, this block walks the 25 operand addresses over the core read port. It collects each returned byte into a shadow bank, then commits all 25 bytes at once to registered, flattened matrix outputs. It sits between the operand memory and the PE / SA_3x3 / SA_2x2 compute cores, which only see a complete, consistent operand set.

## Interface
Parameters:
- None. Widths are fixed: 8-bit data, 5-bit address, 25 entries.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start_i  input  1  load request, level input, typically driven by memory done_capture; a load triggers on its rising edge only.
- addr_core_o  output  5  operand memory read address.
- data_core_i  input  8  operand memory read data; valid the cycle after the matching addr_core_o.
- a_mat_o  output  128  A matrix, row-major; a11 = [7:0], a12 = [15:8], …, a44 = [127:120].
- b_mat_o  output  72  B matrix, row-major; b11 = [7:0], …, b33 = [71:64].
- busy_o  output  1  high while a load is in progress.
- load_valid_o  output  1  one-cycle pulse when new a_mat_o / b_mat_o become visible.

## Operation
Start detection:
- start_q registers start_i; reset value 0.
- start_rise = start_i & ~start_q.
- A held-high start_i produces exactly one load.

FSM states:
- IDLE
  - start_rise -> ISSUE.
  - addr_core_o = 0.
- ISSUE
  - addr_core_o = rd_cnt, with rd_cnt running 0..24, +1 per cycle.
  - When rd_cnt == 24 -> DRAIN.
- DRAIN
  - One cycle; captures the last byte (index 24).
  - -> COMMIT.
- COMMIT
  - shadow -> a_mat_o / b_mat_o.
  - load_valid_o = 1.
  - -> IDLE.

Capture path:
- A 1-cycle-delayed index, cap_idx, with a valid flag, cap_vld, steers data_core_i into the shadow bank.
- Index k < 16 -> shadow A byte k.
- Index k in 16..24 -> shadow B byte k-16.

Outputs and status:
- a_mat_o / b_mat_o change only on the COMMIT edge; between loads they hold.
- busy_o = 1 in ISSUE and DRAIN.
- start_rise while not in IDLE is ignored and not queued. That includes a rise during COMMIT.
- No arithmetic beyond rd_cnt increment. rd_cnt never exceeds 24; there is no wrap.

Reset (reset_n low, any time including mid-load):
- FSM -> IDLE.
- rd_cnt, cap_idx, cap_vld, start_q, shadow bank = 0.
- addr_core_o = 0, a_mat_o = 0, b_mat_o = 0, busy_o = 0, load_valid_o = 0.
- A load interrupted by reset is discarded. A new start_rise after reset release begins a fresh load.

## Timing
Let T be the cycle in which start_rise is high in IDLE.
- Cycle T+1+k, k = 0..24: addr_core_o = k, busy_o = 1.
- Cycle T+2+k: data_core_i holds byte k; it is latched at the end of that cycle.
- Cycle T+26: DRAIN; addr_core_o = 24 held, busy_o = 1; byte 24 is latched.
- Edge ending T+26: outputs update.
- Cycle T+27: COMMIT; load_valid_o = 1, busy_o = 0, new a_mat_o / b_mat_o visible.
- Cycle T+28: IDLE; load_valid_o = 0.

Summary:
- Start to valid: 27 cycles.
- Minimum spacing between accepted start_rise events: 28 cycles.
- Earliest new start_rise: cycle T+28. It requires start_i to have been low in a prior cycle.

## Test plan
- Basic load
  - Stimulus: memory model returns byte k = k+1 one cycle after address k; start_i rises at T.
  - Required: addr_core_o steps 0..24 over T+1..T+25; load_valid_o pulses only at T+27; a_mat_o = 0x100F0E…0201 (a11 = 0x01, a44 = 0x10); b_mat_o b11 = 0x11, b33 = 0x19.
- Atomic update
  - Stimulus: preload with pattern 0xAA; run a second load with pattern 0x55.
  - Required: a_mat_o / b_mat_o read all-0xAA through T+26 and all-0x55 from T+27; no mixed values at any cycle.
- Level start
  - Stimulus: start_i held high for 100 cycles.
  - Required: exactly one load_valid_o pulse; busy_o low after T+27 until start_i drops and rises again.
- Start while busy
  - Stimulus: start_i toggles low/high at T+10.
  - Required: ignored; single pulse at T+27; no second load.
- Reset mid-load
  - Stimulus: reset_n low at T+12 for 2 cycles, then start_i rises again.
  - Required: immediately on reset, all outputs = 0 and busy_o = 0; the new load completes 27 cycles after the new rise with correct data.
- Back-to-back
  - Stimulus: start_i falls at T+20 and rises at T+28.
  - Required: second load accepted; addr_core_o = 0 at T+29; load_valid_o at T+55.
